fft_buf_scheduler: RTL

Frame-synchronous scheduler for the double-buffered FFT magnitude display path. It decides when the FFT writer captures a new 256-bin spectrum and which of two RAM banks the writer fills and the HDMI overlay reads. Bank swaps happen only on a vsync rising edge, so a displayed frame never mixes two spectra. It sits in the pclk domain between the capture FSM (its start/done handshake is already synchronised to pclk) and the display overlay's read-address mux.

---
 rtl/fft_buf_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fft_buf_scheduler.sv
// Frame-synchronous capture scheduler and bank selector for the double-buffered
// FFT magnitude display path; banks swap only on a vsync rising edge.
module fft_buf_scheduler #(
   parameter int unsigned FRAME_DIV = 2,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic enable,
   input  logic i_vs,
   input  logic cap_done,
   input  logic clr_err,
   output logic cap_start,
   output logic wr_bank,
   output logic rd_bank,
   output logic swap,
   output logic busy,
   output logic timeout_err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      PEND_SWAP  = 2'd3
   } state_t;

   localparam logic [7:0]  FRAME_LAST = 8'(FRAME_DIV - 1);
   localparam logic [23:0] TO_LAST    = 24'(TIMEOUT - 1);

   state_t      state_q;
   logic        vs_q;
   logic        vs_dly_q;
   logic [7:0]  frame_cnt_q;
   logic [23:0] to_cnt_q;
   logic        cap_start_q;
   logic        swap_q;
   logic        busy_q;
   logic        err_q;
   logic        wr_bank_q;
   logic        rd_bank_q;
   logic        vs_rise;

   // Both sample stages reset high so a vsync already high at release is not an edge.
   assign vs_rise = vs_q & ~vs_dly_q;

   // Scheduler FSM with all outputs registered alongside the state.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vs_q        <= 1'b1;
         vs_dly_q    <= 1'b1;
         frame_cnt_q <= 8'd0;
         to_cnt_q    <= 24'd0;
         cap_start_q <= 1'b0;
         swap_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b1;
      end else begin
         vs_q        <= i_vs;
         vs_dly_q    <= vs_q;
         cap_start_q <= 1'b0;
         swap_q      <= 1'b0;
         busy_q      <= (state_q == CAPTURE) || (state_q == PEND_SWAP);
         // A timeout set further down overrides this clear.
         if (clr_err) begin
            err_q <= 1'b0;
         end else begin
            err_q <= err_q;
         end

         if (!enable) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q     <= WAIT_FRAME;
                  frame_cnt_q <= 8'd0;
               end
               WAIT_FRAME: begin
                  if (vs_rise) begin
                     if (frame_cnt_q == FRAME_LAST) begin
                        cap_start_q <= 1'b1;
                        frame_cnt_q <= 8'd0;
                        to_cnt_q    <= 24'd0;
                        state_q     <= CAPTURE;
                     end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                     end
                  end else begin
                     state_q <= WAIT_FRAME;
                  end
               end
               CAPTURE: begin
                  to_cnt_q <= to_cnt_q + 24'd1;
                  if (cap_done) begin
                     state_q <= PEND_SWAP;
                  end else if (to_cnt_q == TO_LAST) begin
                     err_q       <= 1'b1;
                     frame_cnt_q <= 8'd0;
                     state_q     <= WAIT_FRAME;
                  end else begin
                     state_q <= CAPTURE;
                  end
               end
               PEND_SWAP: begin
                  if (vs_rise) begin
                     wr_bank_q   <= ~wr_bank_q;
                     rd_bank_q   <= ~rd_bank_q;
                     swap_q      <= 1'b1;
                     frame_cnt_q <= 8'd0;
                     state_q     <= WAIT_FRAME;
                  end else begin
                     state_q <= PEND_SWAP;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign cap_start   = cap_start_q;
   assign swap        = swap_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;
   assign wr_bank     = wr_bank_q;
   assign rd_bank     = rd_bank_q;

endmodule
